// File: rtl/cpu57_fetch_unit_pkg.sv
// cpu57_fetch_unit_pkg: instruction layout, opcodes and fetch FSM states shared by the cpu57 fetch path
package cpu57_fetch_unit_pkg;
    localparam int INSTR_BYTES = 10;
    localparam int OFF_OPCODE = 0;
    localparam int OFF_RD = 1;
    localparam int OFF_RS1 = 2;
    localparam int OFF_RS2 = 3;
    localparam int OFF_IMM = 4;
    localparam int IMM_BYTES = 6;
    localparam logic [7:0] OP_HALT = 8'hFF;
    localparam logic [7:0] OP_LOADI = 8'h12;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_MUL = 8'h03;
    localparam logic [7:0] OP_OUT = 8'h41;
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_FULL, S_HALT, S_DRAIN} state_t;
endpackage

// File: rtl/cpu57_instr_fifo.sv
// cpu57_instr_fifo: synchronous FIFO with flush; head reads as zero while empty
module cpu57_instr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic do_push, do_pop;

    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign rdata = empty ? '0 : mem[rptr];

    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wdata;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr <= '0;
            wptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr == PW'(DEPTH - 1) ? '0 : wptr + 1'b1;
            if (do_pop) rptr <= rptr == PW'(DEPTH - 1) ? '0 : rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/cpu57_fetch_unit.sv
// cpu57_fetch_unit: byte-serial fetch of 10-byte instructions into a small queue,
// with redirect flush, in-flight byte draining and prefetch stop after HALT
module cpu57_fetch_unit
    import cpu57_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 57,
    parameter int QDEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [7:0] HALT_OPCODE = OP_HALT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [7:0]        instr_rd,
    output logic [7:0]        instr_rs1,
    output logic [7:0]        instr_rs2,
    output logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_halted
);
    localparam int WIDTH = 32 + DATA_W + ADDR_W;
    localparam int CW = $clog2(QDEPTH + 1);

    state_t state;
    logic [ADDR_W-1:0] pc;
    logic [3:0] byte_idx;
    logic [7:0] asm_b [INSTR_BYTES-1];
    logic [CW-1:0] q_count;
    logic [WIDTH-1:0] q_wdata, q_rdata;
    logic [8*IMM_BYTES-1:0] imm;
    logic q_empty, last, enq, deq, halt_op, full_after;

    assign mem_req = state == S_REQ && !rst;
    assign mem_addr = pc + ADDR_W'(byte_idx);
    assign last = byte_idx == 4'(INSTR_BYTES - 1);
    assign enq = state == S_WAIT && mem_rvalid && last && !redirect_valid;
    assign deq = instr_valid && instr_ready;
    assign halt_op = asm_b[OFF_OPCODE] == HALT_OPCODE;
    assign full_after = q_count == CW'(QDEPTH - 1) && !deq;
    // byte 9 is taken straight off the bus so the enqueue happens on its arrival
    assign imm = {mem_rdata, asm_b[8], asm_b[7], asm_b[6], asm_b[5], asm_b[OFF_IMM]};
    assign q_wdata = {asm_b[OFF_OPCODE], asm_b[OFF_RD], asm_b[OFF_RS1], asm_b[OFF_RS2], DATA_W'(imm), pc};
    assign instr_valid = !q_empty;
    assign {instr_opcode, instr_rd, instr_rs1, instr_rs2, instr_imm, instr_pc} = q_rdata;

    cpu57_instr_fifo #(.WIDTH(WIDTH), .DEPTH(QDEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect_valid),
        .push(enq),
        .pop(deq),
        .wdata(q_wdata),
        .rdata(q_rdata),
        .count(q_count),
        .empty(q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
            pc <= RESET_PC;
            byte_idx <= '0;
            fetch_halted <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            byte_idx <= '0;
            fetch_halted <= 1'b0;
            state <= (state == S_REQ || ((state == S_WAIT || state == S_DRAIN) && !mem_rvalid)) ? S_DRAIN : S_REQ;
        end else begin
            case (state)
                S_REQ: state <= S_WAIT;
                S_WAIT:
                    if (mem_rvalid && last) begin
                        pc <= pc + ADDR_W'(INSTR_BYTES);
                        byte_idx <= '0;
                        fetch_halted <= halt_op;
                        state <= halt_op ? S_HALT : full_after ? S_FULL : S_REQ;
                    end else if (mem_rvalid) begin
                        asm_b[byte_idx] <= mem_rdata;
                        byte_idx <= byte_idx + 1'b1;
                        state <= S_REQ;
                    end
                S_FULL: if (q_count != CW'(QDEPTH) || deq) state <= S_REQ;
                S_DRAIN: if (mem_rvalid) state <= S_REQ;
                default: ;
            endcase
        end
    end

    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        mem_rvalid |-> (state == S_WAIT || state == S_DRAIN));
endmodule

// File: tb/tb_cpu57_fetch_unit.sv
// tb_cpu57_fetch_unit: vector table, directed corner sequences and a randomized run
// against a program-order reference model with a latency-programmable byte memory
module tb_cpu57_fetch_unit;
    import cpu57_fetch_unit_pkg::*;

    logic clk = 0;
    logic rst = 1;
    logic mem_req, mem_rvalid;
    logic [15:0] mem_addr;
    logic [7:0] mem_rdata;
    logic redirect_valid = 0;
    logic [15:0] redirect_pc = 0;
    logic instr_valid, instr_ready = 0, fetch_halted;
    logic [7:0] instr_opcode, instr_rd, instr_rs1, instr_rs2;
    logic [56:0] instr_imm;
    logic [15:0] instr_pc;

    cpu57_fetch_unit dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm(instr_imm), .instr_pc(instr_pc), .fetch_halted(fetch_halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [65536];
    int L = 1;
    int mcnt;
    logic [15:0] raddr;

    // byte memory: answers each request exactly L cycles after the request cycle
    always @(posedge clk) begin
        if (rst) begin
            mcnt <= 0;
            mem_rvalid <= 1'b0;
            mem_rdata <= 8'h00;
        end else begin
            mem_rvalid <= 1'b0;
            if (mem_req) begin
                raddr <= mem_addr;
                if (L == 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata <= mem[mem_addr];
                end else mcnt <= L - 1;
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata <= mem[raddr];
                end
            end
        end
    end

    typedef struct {
        string name;
        logic [15:0] pc;
        int lat;
        logic [79:0] b;
        logic [7:0] op, rd, rs1, rs2;
        logic [56:0] imm;
        logic halt;
    } vec_t;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 7 + 3) & 8'h7F);
    endtask

    task automatic do_reset(input int lat);
        rst = 1;
        L = lat;
        redirect_valid = 0;
        tick();
        tick();
        rst = 0;
        settle();
    endtask

    task automatic start_at(input logic [15:0] p, input int lat);
        rst = 1;
        L = lat;
        redirect_valid = 0;
        tick();
        tick();
        rst = 0;
        redirect_valid = 1;
        redirect_pc = p;
        tick();
        redirect_valid = 0;
        settle();
    endtask

    function automatic logic [104:0] ref_instr(input logic [15:0] p);
        logic [47:0] imm;
        for (int i = 0; i < 6; i++) imm[8*i +: 8] = mem[16'(p + 16'(4 + i))];
        return {mem[p], mem[16'(p + 16'd1)], mem[16'(p + 16'd2)], mem[16'(p + 16'd3)], 57'(imm), p};
    endfunction

    vec_t vt [6];
    int n, first, k, bad, cnt, accepted;
    logic [15:0] last_addr, exp_pc;
    logic exp_done, outstanding, prev_hold;
    logic [104:0] prev_head, head;

    initial begin
        vt[0] = '{"loadi", 16'h0000, 1, 80'h00000000006400000012, OP_LOADI, 8'h00, 8'h00, 8'h00, 57'd100, 1'b0};
        vt[1] = '{"mul", 16'h0028, 3, 80'h00000000000003000203, OP_MUL, 8'h02, 8'h00, 8'h03, 57'd0, 1'b0};
        vt[2] = '{"sub", 16'h0064, 2, 80'h1234DEADBEEF06050102, OP_SUB, 8'h01, 8'h05, 8'h06, 57'h1234DEADBEEF, 1'b0};
        vt[3] = '{"out_wrap", 16'hFFFC, 1, 80'h06050403020109080741, OP_OUT, 8'h07, 8'h08, 8'h09, 57'h060504030201, 1'b0};
        vt[4] = '{"halt", 16'h0046, 2, 80'h000000000000000000FF, OP_HALT, 8'h00, 8'h00, 8'h00, 57'd0, 1'b1};
        vt[5] = '{"imm_ones", 16'h00C8, 4, 80'hFFFFFFFFFFFF00000312, OP_LOADI, 8'h03, 8'h00, 8'h00, 57'hFFFFFFFFFFFF, 1'b0};

        // table: single instruction fetched after redirect, head fields and first-request latency
        fill_pattern();
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 10; i++) mem[16'(vt[v].pc + 16'(i))] = vt[v].b[8*i +: 8];
            instr_ready = 0;
            start_at(vt[v].pc, vt[v].lat);
            first = -1;
            for (n = 0; n < 400 && !instr_valid; n++) begin
                if (mem_req && first < 0) first = n;
                tick();
            end
            chk({vt[v].name, "/latency"}, n - first, 10 * (1 + vt[v].lat));
            chk({vt[v].name, "/opcode"}, instr_opcode, vt[v].op);
            chk({vt[v].name, "/rd"}, instr_rd, vt[v].rd);
            chk({vt[v].name, "/rs1"}, instr_rs1, vt[v].rs1);
            chk({vt[v].name, "/rs2"}, instr_rs2, vt[v].rs2);
            chk({vt[v].name, "/imm"}, instr_imm, vt[v].imm);
            chk({vt[v].name, "/pc"}, instr_pc, vt[v].pc);
            chk({vt[v].name, "/halted"}, fetch_halted, vt[v].halt);
        end

        // reset state, first request, LOADI at cycle 20, next fetch address
        fill_pattern();
        for (int i = 0; i < 10; i++) mem[i] = 8'h00;
        mem[0] = OP_LOADI;
        mem[4] = 8'd100;
        instr_ready = 1;
        rst = 1;
        L = 1;
        tick();
        tick();
        chk("reset/outputs", {mem_req, instr_valid, fetch_halted, instr_opcode, instr_pc}, '0);
        rst = 0;
        settle();
        chk("reset/first_req", {mem_req, mem_addr}, {1'b1, 16'h0000});
        for (n = 0; n < 400 && !instr_valid; n++) tick();
        chk("t1/cycle", n, 20);
        chk("t1/fields", {instr_opcode, instr_rd, instr_imm, instr_pc}, {8'h12, 8'h00, 57'd100, 16'h0000});
        chk("t1/next_addr", {mem_req, mem_addr}, {1'b1, 16'd10});

        // queue fills and prefetch stops; one accept resumes at the third instruction
        fill_pattern();
        instr_ready = 0;
        do_reset(1);
        last_addr = 16'hDEAD;
        for (int i = 0; i < 100; i++) begin
            if (mem_req) last_addr = mem_addr;
            tick();
        end
        chk("t2/last_addr", last_addr, 16'd19);
        chk("t2/stalled", {mem_req, instr_valid, instr_pc}, {1'b0, 1'b1, 16'd0});
        instr_ready = 1;
        tick();
        instr_ready = 0;
        settle();
        chk("t2/head_after_accept", instr_pc, 16'd10);
        for (n = 0; n < 50 && !mem_req; n++) tick();
        chk("t2/resume_addr", {mem_req, mem_addr}, {1'b1, 16'd20});

        // redirect while byte 13 is in flight with L=3
        fill_pattern();
        for (int i = 40; i < 50; i++) mem[i] = 8'h00;
        mem[40] = OP_MUL;
        mem[41] = 8'h02;
        mem[43] = 8'h03;
        instr_ready = 0;
        do_reset(3);
        for (n = 0; n < 400 && !(mem_req && mem_addr == 16'd13); n++) tick();
        tick();
        chk("t3/queued_before", {mem_rvalid, instr_valid, instr_pc}, {1'b0, 1'b1, 16'd0});
        redirect_valid = 1;
        redirect_pc = 16'd40;
        tick();
        redirect_valid = 0;
        settle();
        chk("t3/flushed", instr_valid, 1'b0);
        for (n = 0; n < 50 && !mem_req; n++) tick();
        chk("t3/redirect_addr", {mem_req, mem_addr}, {1'b1, 16'd40});
        for (n = 0; n < 400 && !instr_valid; n++) tick();
        chk("t3/head", {instr_opcode, instr_rd, instr_rs2, instr_pc}, {8'h03, 8'h02, 8'h03, 16'd40});

        // HALT stops requests until a redirect
        fill_pattern();
        mem[70] = OP_HALT;
        instr_ready = 1;
        start_at(16'd70, 2);
        for (n = 0; n < 400 && !fetch_halted; n++) tick();
        chk("t4/halted", {fetch_halted, instr_valid, instr_opcode, instr_pc}, {1'b1, 1'b1, 8'hFF, 16'd70});
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (mem_req) cnt++;
            tick();
        end
        chk("t4/quiet_reqs", cnt, 0);
        redirect_valid = 1;
        redirect_pc = 16'd0;
        tick();
        redirect_valid = 0;
        settle();
        chk("t4/restart", {fetch_halted, mem_req, mem_addr}, {1'b0, 1'b1, 16'd0});

        // reset in the middle of the second instruction
        fill_pattern();
        instr_ready = 0;
        do_reset(1);
        for (n = 0; n < 400 && !(mem_req && mem_addr == 16'd15); n++) tick();
        chk("t5/queued_before", instr_valid, 1'b1);
        rst = 1;
        tick();
        chk("t5/in_reset", {instr_valid, mem_req}, 2'b00);
        tick();
        rst = 0;
        settle();
        chk("t5/first_after", {mem_req, mem_addr}, {1'b1, 16'd0});

        // address wrap across 16'hFFFF
        fill_pattern();
        instr_ready = 0;
        start_at(16'hFFFC, 1);
        k = 0;
        bad = 0;
        for (n = 0; n < 400 && !instr_valid; n++) begin
            if (mem_req) begin
                if (mem_addr !== 16'(16'hFFFC + 16'(k))) bad++;
                k++;
            end
            tick();
        end
        chk("t6/wrap_addrs", {k, bad}, {32'd10, 32'd0});
        chk("t6/pc", instr_pc, 16'hFFFC);
        instr_ready = 1;
        tick();
        instr_ready = 0;
        settle();
        for (n = 0; n < 400 && !instr_valid; n++) tick();
        chk("t6/next_pc", instr_pc, 16'h0006);

        // randomized: accepted instructions follow program order from each restart point
        for (int i = 0; i < 65536; i++) mem[i] = ($urandom % 32 == 0) ? 8'hFF : 8'($urandom);
        instr_ready = 0;
        do_reset(1 + int'($urandom % 4));
        exp_pc = 16'd0;
        exp_done = 0;
        outstanding = 0;
        prev_hold = 0;
        prev_head = '0;
        accepted = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) L = 1 + int'($urandom % 4);
            instr_ready = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 120) == 0;
            redirect_pc = ($urandom % 4 == 0) ? 16'hFFF0 + 16'($urandom % 16) : 16'($urandom);
            settle();
            head = {instr_opcode, instr_rd, instr_rs1, instr_rs2, instr_imm, instr_pc};
            if (prev_hold) chk("rand/hold", {instr_valid, head}, {1'b1, prev_head});
            if (mem_req) chk("rand/one_outstanding", outstanding, 1'b0);
            if (fetch_halted) chk("rand/halt_quiet", mem_req, 1'b0);
            if (mem_rvalid) outstanding = 0;
            if (mem_req) outstanding = 1;
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                exp_done = 0;
            end else if (instr_valid && instr_ready) begin
                chk("rand/instr", {exp_done, head}, {1'b0, ref_instr(exp_pc)});
                exp_pc = 16'(exp_pc + 16'd10);
                if (instr_opcode == 8'hFF) exp_done = 1;
                accepted++;
            end
            prev_hold = instr_valid && !instr_ready && !redirect_valid;
            prev_head = head;
            tick();
        end
        redirect_valid = 0;
        chk("rand/progress", accepted > 20, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
